// File: rtl/sel_arbiter_pkg.sv
// Shared definitions for the two-requester select arbiter: state encoding,
// default sizing and the state-to-grant decode.
package sel_arbiter_pkg;

  localparam int unsigned DEF_MAX_HOLD = 8;
  localparam int unsigned DEF_CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  typedef struct packed {
    logic gnt0;
    logic gnt1;
    logic sel;
    logic busy;
  } grant_t;

  // Output image of a state; the unused encoding decodes to idle
  function automatic grant_t decode_state(input state_t st);
    grant_t g;
    g = '0;
    case (st)
      ST_OWN0: begin
        g.gnt0 = 1'b1;
        g.busy = 1'b1;
      end
      ST_OWN1: begin
        g.gnt1 = 1'b1;
        g.sel  = 1'b1;
        g.busy = 1'b1;
      end
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sel_arbiter_hold_counter.sv
// Saturating hold counter: counts cycles of continuous ownership and flags
// when the owner has reached its hold limit.
module sel_arbiter_hold_counter #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned MAX_VAL = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  assign at_max = (cnt == CNT_W'(MAX_VAL));

  // Clear wins over enable; the count parks at MAX_VAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sel_arbiter.sv
// Two-requester round-robin arbiter owning the select line of the shared
// 1-to-2 decoder; a hold counter bounds ownership while the other side waits.
module sel_arbiter
  import sel_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             done0,
  input  logic             done1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  state_t state_q;
  state_t state_d;
  logic   last_q;
  logic   last_d;
  logic   at_max;
  logic   cnt_clr;
  logic   cnt_en;
  grant_t grant_d;

  // Next-state: release on done, dropped request, or hold limit with a waiter
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_OWN0: begin
        if (done0 || !req0 || (at_max && req1)) begin
          state_d = req1 ? ST_OWN1 : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (done1 || !req1 || (at_max && req0)) begin
          state_d = req0 ? ST_OWN0 : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (req0 && (!req1 || last_q)) begin
          state_d = ST_OWN0;
        end else if (req1) begin
          state_d = ST_OWN1;
        end
      end
    endcase
    if (state_d != state_q) begin
      if (state_d == ST_OWN0) last_d = 1'b0;
      if (state_d == ST_OWN1) last_d = 1'b1;
    end
  end

  assign cnt_clr = (state_d != state_q) || (state_d == ST_IDLE);
  assign cnt_en  = !cnt_clr;
  assign grant_d = decode_state(state_d);

  // State, priority pointer and grant outputs all register together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      sel     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt0    <= grant_d.gnt0;
      gnt1    <= grant_d.gnt1;
      sel     <= grant_d.sel;
      busy    <= grant_d.busy;
    end
  end

  sel_arbiter_hold_counter #(
    .CNT_W  (CNT_W),
    .MAX_VAL(MAX_HOLD - 1)
  ) u_hold_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (hold_cnt),
    .at_max(at_max)
  );

endmodule
